// File: rtl/imem_responder.sv
// imem_responder
//   Responder side of the instruction-fetch interface. It accepts one fetch
//   request at a time, looks up a 32-bit word in an internal word-addressed
//   ROM, and returns that word after LATENCY wait cycles using a valid/ready
//   handshake. A separate write port loads the ROM and operates independently
//   of the fetch FSM.
//
//   Parameters
//     BASE_ADDR  byte address of ROM word 0 (word aligned)
//     DEPTH      ROM size in 32-bit words (power of 2)
//     LATENCY    wait cycles between request accept and resp_valid (0..15)
//
//   Ports
//     clk         clock, rising edge
//     rst         asynchronous reset, active-high
//     req_valid   fetch request valid
//     req_ready   responder can accept a request (IDLE only)
//     req_addr    fetch byte address (PC)
//     resp_valid  response valid
//     resp_ready  core accepts the response
//     resp_instr  fetched instruction (nop on error)
//     resp_err    misaligned or out-of-range fetch
//     wr_en       ROM load strobe
//     wr_addr     ROM load byte address (low 2 bits ignored)
//     wr_data     ROM load data
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | ready for a request; req_ready=1
//   WAIT   | request latched; latency down-counter running
//   RESP   | response held on resp_* until resp_ready
module imem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [63:0] END_ADDR  = BASE_ADDR + 64'(4 * DEPTH);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        load_resp;

  logic [31:0] rom [DEPTH];

  // With LATENCY=0 the ROM is sampled on the accepting edge itself, so the
  // lookup must use the live request address rather than the latched one.
  logic [63:0]      fetch_addr;
  logic             fetch_err;
  logic [IDX_W-1:0] fetch_idx;
  logic [31:0]      rom_rd;

  always_comb begin
    fetch_addr = (state_q == S_IDLE) ? req_addr : addr_q;
    fetch_err  = (fetch_addr[1:0] != 2'b00) ||
                 (fetch_addr < BASE_ADDR) ||
                 (fetch_addr >= END_ADDR);
    // Modular subtraction on the index bits only; valid once the range
    // check has passed.
    fetch_idx  = fetch_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    rom_rd     = rom[fetch_idx];
  end

  // ROM load port
  logic [63:0]      wr_word;
  logic             wr_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic             unused_wr_low;

  always_comb begin
    wr_word     = {wr_addr[63:2], 2'b00};
    wr_in_range = (wr_word >= BASE_ADDR) && (wr_word < END_ADDR);
    wr_idx      = wr_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
  end

  assign unused_wr_low = ^wr_addr[1:0];

  // ROM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      rom[wr_idx] <= wr_data;
    end
  end

  // FSM next-state and response capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    err_d     = err_q;
    load_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY == 0) begin
            state_d   = S_RESP;
            load_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_RESP;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ROM is read on the edge entering RESP; a same-edge write lands after
    // this read, so the old word is returned.
    if (load_resp) begin
      err_d   = fetch_err;
      instr_d = fetch_err ? NOP : rom_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      instr_q <= NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_instr = instr_q;
  assign resp_err   = err_q;

endmodule
